mac_job_arbiter: RTL and testbench
==================================

MAC_JOB_ARBITER -- requirements
Module: mac_job_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 2, meaning the number of requesters sharing one mac_top.
REQ-002 The module SHALL have parameters param_M, param_K and param_N, each default 4, meaning the matrix dimensions passed to mac_top.
REQ-003 The module SHALL have parameters DATA_WIDTH_INITIAL (default 8) and DATA_WIDTH_FINAL (default 2*DATA_WIDTH_INITIAL), meaning operand and result element widths.
REQ-004 The module SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the compute watchdog limit.
REQ-005 Port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 Port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port req_val, input, [NUM_REQ]: requester i has a job pending.
REQ-008 Port req_rdy, output, [NUM_REQ]: one-cycle pulse; requester i's operands have been accepted.
REQ-009 Ports req_a and req_b, input, [NUM_REQ][M*K or K*N][DATA_WIDTH_INITIAL]: per-requester operand matrices.
REQ-010 Port resp_val, output, [NUM_REQ]: result valid for requester i.
REQ-011 Port resp_rdy, input, [NUM_REQ]: requester i accepts the result.
REQ-012 Port resp_c, output, [M*N][DATA_WIDTH_FINAL]: shared result bus, meaningful only where resp_val is high.
REQ-013 Mac_top-side ports: m_h2b_val (out, 1), m_h2b_rdy (in, 1), m_b2h_val (in, 1), m_b2h_rdy (out, 1), m_ab_we (out, 1), m_c_re (out, 1), m_a (out, M*K elements), m_b (out, K*N elements), m_c (in, M*N elements), m_done (in, 1).
REQ-014 Port grant_id, output, $clog2(NUM_REQ) bits: the current owner of mac_top.
REQ-015 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 Port err_timeout, output, 1 bit: sticky watchdog flag.
REQ-017 Port job_cnt, output, 16 bits: count of completed jobs, wrapping at 65535 to 0.

Function
REQ-018 The FSM states SHALL be IDLE, LOAD, WAIT, READ, CAPT and RESP.
REQ-019 IDLE: if any req_val is high, the module SHALL latch the round-robin winner into grant_id and go to LOAD next cycle; otherwise it stays in IDLE.
REQ-020 The round-robin search SHALL start at rr_ptr and wrap, so the lowest index at or above rr_ptr with req_val high wins.
REQ-021 LOAD: m_h2b_val=1; in the cycle m_h2b_rdy=1, the module SHALL drive m_ab_we=1, pulse req_rdy[grant_id], and go to WAIT.
REQ-022 m_a and m_b SHALL equal req_a[grant_id] and req_b[grant_id] combinationally at all times.
REQ-023 WAIT: m_b2h_rdy=1; on m_b2h_val=1 the module SHALL go to READ.
REQ-024 READ: m_c_re=1 and m_b2h_rdy=1 for exactly one cycle, then the module SHALL go to CAPT.
REQ-025 CAPT: m_b2h_rdy=1; the module SHALL register m_c into the result register (mac memory read latency is 1 cycle), then go to RESP.
REQ-026 RESP: m_b2h_rdy=0 (releases mac_top); resp_val[grant_id]=1 with resp_c = result register.
REQ-027 In RESP, when resp_rdy[grant_id]=1, the module SHALL go to IDLE, set rr_ptr = (grant_id+1) mod NUM_REQ, and increment job_cnt.
REQ-028 Every output not asserted by the current state SHALL be 0, and at most one bit of req_rdy and of resp_val SHALL be high in any cycle.
REQ-029 A req_val that falls after grant SHALL NOT abort the job; the job completes and its result is presented normally.
REQ-030 A requester's req_val arriving while busy SHALL be held off with no req_rdy until arbitration.
REQ-031 resp_rdy on a non-granted index SHALL be ignored.
REQ-032 Watchdog: a counter SHALL clear on entry to WAIT and count each WAIT cycle; when it reaches TIMEOUT_CYCLES, err_timeout SHALL be set to 1 and held until reset.
REQ-033 When the watchdog fires, the FSM SHALL remain in WAIT.
REQ-034 Back-to-back jobs: IDLE SHALL always be occupied for at least 1 cycle between jobs.

Reset
REQ-035 While rstn=0, asynchronously: state=IDLE, rr_ptr=0, grant_id=0, job_cnt=0, err_timeout=0, watchdog=0, result register=0, and all handshake and strobe outputs=0.
REQ-036 A reset asserted mid-job SHALL discard the job with no req_rdy or resp_val emitted.

Structure
REQ-037 The state enum and default widths SHALL live in the shared package mac_pkg.
REQ-038 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req and ptr; outputs gnt_vld and gnt_idx).

Verification
REQ-039 Single job: req_val=01 with A=I and B=all 2 -> req_rdy[0] pulses once, resp_val[0] asserts with every C element equal to 2, and job_cnt=1.
REQ-040 Contention: req_val=11 from reset -> requester 0 is served first, then requester 1, and rr_ptr ends at 0.
REQ-041 Fairness: requester 0 re-requests immediately and req_val stays 11 for 6 jobs -> grants alternate 0,1,0,1,0,1.
REQ-042 Backpressure: resp_rdy held 0 for 20 cycles in RESP -> resp_val stays high and resp_c stable, with no new grant.
REQ-043 Timeout: mac_top model withholds m_done with TIMEOUT_CYCLES=16 -> err_timeout rises on WAIT cycle 16 and stays high.
REQ-044 Reset mid-job: rstn pulsed low during WAIT -> all outputs are 0 immediately and the next request is granted to index 0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default sizes for the MAC job arbiter slice.
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        READ,
        CAPT,
        RESP
    } state_t;

    localparam int unsigned DEF_NUM_REQ    = 2;
    localparam int unsigned DEF_DIM        = 4;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_TIMEOUT    = 1024;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_job_arbiter_rr.sv
// Round-robin pick: lowest requesting index at or above ptr, wrapping past NUM_REQ-1.
module rr_arbiter
    import mac_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               gnt_vld,
    output logic [ID_W-1:0]    gnt_idx
);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = ID_W'((32'(ptr) + off) % NUM_REQ);
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/mac_job_arbiter.sv
// Shares one mac_top among NUM_REQ requesters: arbitrate, load operands, wait,
// read back the product and hold it for the winner until accepted.
module mac_job_arbiter
    import mac_pkg::*;
#(
    parameter int unsigned NUM_REQ            = DEF_NUM_REQ,
    parameter int unsigned param_M            = DEF_DIM,
    parameter int unsigned param_K            = DEF_DIM,
    parameter int unsigned param_N            = DEF_DIM,
    parameter int unsigned DATA_WIDTH_INITIAL = DEF_DATA_WIDTH,
    parameter int unsigned DATA_WIDTH_FINAL   = 2 * DATA_WIDTH_INITIAL,
    parameter int unsigned TIMEOUT_CYCLES     = DEF_TIMEOUT,
    localparam int unsigned ID_W              = idx_width(NUM_REQ)
) (
    input  logic                                                            clk,
    input  logic                                                            rstn,
    input  logic [NUM_REQ-1:0]                                              req_val,
    output logic [NUM_REQ-1:0]                                              req_rdy,
    input  logic [NUM_REQ-1:0][param_M*param_K-1:0][DATA_WIDTH_INITIAL-1:0] req_a,
    input  logic [NUM_REQ-1:0][param_K*param_N-1:0][DATA_WIDTH_INITIAL-1:0] req_b,
    output logic [NUM_REQ-1:0]                                              resp_val,
    input  logic [NUM_REQ-1:0]                                              resp_rdy,
    output logic [param_M*param_N-1:0][DATA_WIDTH_FINAL-1:0]                resp_c,
    output logic                                                            m_h2b_val,
    input  logic                                                            m_h2b_rdy,
    input  logic                                                            m_b2h_val,
    output logic                                                            m_b2h_rdy,
    output logic                                                            m_ab_we,
    output logic                                                            m_c_re,
    output logic [param_M*param_K-1:0][DATA_WIDTH_INITIAL-1:0]              m_a,
    output logic [param_K*param_N-1:0][DATA_WIDTH_INITIAL-1:0]              m_b,
    input  logic [param_M*param_N-1:0][DATA_WIDTH_FINAL-1:0]                m_c,
    input  logic                                                            m_done,
    output logic [ID_W-1:0]                                                 grant_id,
    output logic                                                            busy,
    output logic                                                            err_timeout,
    output logic [15:0]                                                     job_cnt
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                                          state, state_nxt;
    logic [ID_W-1:0]                                 rr_ptr;
    logic                                            gnt_vld;
    logic [ID_W-1:0]                                 gnt_idx;
    logic [WD_W-1:0]                                 wdog;
    logic [param_M*param_N-1:0][DATA_WIDTH_FINAL-1:0] result;
    logic                                            unused_done;

    // Completion is taken from the b2h handshake; m_done is informational only.
    assign unused_done = m_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req     (req_val),
        .ptr     (rr_ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign m_a  = req_a[grant_id];
    assign m_b  = req_b[grant_id];
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        m_h2b_val = 1'b0;
        m_ab_we   = 1'b0;
        m_b2h_rdy = 1'b0;
        m_c_re    = 1'b0;
        req_rdy   = '0;
        resp_val  = '0;
        resp_c    = '0;
        case (state)
            IDLE: if (gnt_vld) state_nxt = LOAD;
            LOAD: begin
                m_h2b_val = 1'b1;
                if (m_h2b_rdy) begin
                    m_ab_we           = 1'b1;
                    req_rdy[grant_id] = 1'b1;
                    state_nxt         = WAIT;
                end
            end
            WAIT: begin
                m_b2h_rdy = 1'b1;
                if (m_b2h_val) state_nxt = READ;
            end
            READ: begin
                m_c_re    = 1'b1;
                m_b2h_rdy = 1'b1;
                state_nxt = CAPT;
            end
            CAPT: begin
                m_b2h_rdy = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                resp_val[grant_id] = 1'b1;
                resp_c             = result;
                if (resp_rdy[grant_id]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_id    <= '0;
            rr_ptr      <= '0;
            wdog        <= '0;
            err_timeout <= 1'b0;
            result      <= '0;
            job_cnt     <= '0;
        end else begin
            if (state == IDLE && gnt_vld) grant_id <= gnt_idx;

            // Watchdog saturates at the limit so the flag cannot re-arm by wrapping.
            if (state == LOAD && m_h2b_rdy) begin
                wdog <= '0;
            end else if (state == WAIT && wdog != WD_W'(TIMEOUT_CYCLES)) begin
                wdog <= wdog + 1'b1;
            end
            if (state == WAIT && wdog == WD_W'(TIMEOUT_CYCLES - 1)) err_timeout <= 1'b1;

            if (state == CAPT) result <= m_c;

            if (state == RESP && resp_rdy[grant_id]) begin
                rr_ptr  <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                job_cnt <= job_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_job_arbiter.sv
// Randomised job traffic against a job-level round-robin model and a mac_top stub.
module tb_mac_job_arbiter;

    localparam int NR  = 2;
    localparam int PM  = 4;
    localparam int PK  = 4;
    localparam int PN  = 4;
    localparam int DW  = 8;
    localparam int DWF = 16;
    localparam int TO  = 16;
    localparam int MK  = PM * PK;
    localparam int KN  = PK * PN;
    localparam int MN  = PM * PN;

    logic                            clk = 1'b0;
    logic                            rstn = 1'b1;
    logic [NR-1:0]                   req_val, req_rdy, resp_val, resp_rdy;
    logic [NR-1:0][MK-1:0][DW-1:0]   req_a;
    logic [NR-1:0][KN-1:0][DW-1:0]   req_b;
    logic [MN-1:0][DWF-1:0]          resp_c, m_c;
    logic                            m_h2b_val, m_h2b_rdy, m_b2h_val, m_b2h_rdy;
    logic                            m_ab_we, m_c_re, m_done;
    logic [MK-1:0][DW-1:0]           m_a;
    logic [KN-1:0][DW-1:0]           m_b;
    logic [0:0]                      grant_id;
    logic                            busy, err_timeout;
    logic [15:0]                     job_cnt;

    mac_job_arbiter #(
        .NUM_REQ            (NR),
        .param_M            (PM),
        .param_K            (PK),
        .param_N            (PN),
        .DATA_WIDTH_INITIAL (DW),
        .DATA_WIDTH_FINAL   (DWF),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_c      (resp_c),
        .m_h2b_val   (m_h2b_val),
        .m_h2b_rdy   (m_h2b_rdy),
        .m_b2h_val   (m_b2h_val),
        .m_b2h_rdy   (m_b2h_rdy),
        .m_ab_we     (m_ab_we),
        .m_c_re      (m_c_re),
        .m_a         (m_a),
        .m_b         (m_b),
        .m_c         (m_c),
        .m_done      (m_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout),
        .job_cnt     (job_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Requester / scoreboard state
    logic [NR-1:0]          pend = '0;
    int                     owner = -1;
    bit                     accepted = 0;
    logic [MN-1:0][DWF-1:0] exp_c = '0;
    logic [MN-1:0][DWF-1:0] last_resp_c = '0;
    int                     ptr_m = 0;
    logic [15:0]            cnt_m = '0;
    bit                     exp_err = 0;
    bit                     prev_idle = 0;
    logic [NR-1:0]          prev_req = '0;
    bit                     done_last = 0;
    int                     jobs_done = 0;
    int                     n_acc [NR];
    int                     grants[$];

    // Stimulus modes
    bit auto_req = 0, rerequest = 0, drop_en = 0, h2b_rand = 0, mac_hold = 0;
    int resp_mode = 0;

    // mac_top stub
    bit                     mac_job = 0, pend_c = 0;
    int                     mac_cnt = 0;
    int                     wait_k = 0;
    logic [MN-1:0][DWF-1:0] mac_c = '0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    function automatic logic [MN-1:0][DWF-1:0] matmul(input logic [MK-1:0][DW-1:0] a,
                                                      input logic [KN-1:0][DW-1:0] b);
        logic [MN-1:0][DWF-1:0] c;
        int acc;
        for (int i = 0; i < PM; i++)
            for (int j = 0; j < PN; j++) begin
                acc = 0;
                for (int k = 0; k < PK; k++) acc += int'(a[i*PK+k]) * int'(b[k*PN+j]);
                c[i*PN+j] = acc[DWF-1:0];
            end
        return c;
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] req, input int ptr);
        int idx;
        for (int k = 0; k < NR; k++) begin
            idx = (ptr + k) % NR;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic new_job(input int i, input bit special);
        for (int e = 0; e < MK; e++) req_a[i][e] = special ? ((e / PK == e % PK) ? 8'd1 : 8'd0) : 8'($urandom);
        for (int e = 0; e < KN; e++) req_b[i][e] = special ? 8'd2 : 8'($urandom);
        pend[i] = 1'b1;
    endtask

    task automatic observe();
        int g;
        if (mac_hold && mac_job) begin
            wait_k++;
            if (wait_k > TO) exp_err = 1;
        end
        chk("err_timeout", 256'(err_timeout), 256'(exp_err));

        if (done_last) begin
            chk("idle_gap", 256'(busy), 256'(0));
            chk("job_cnt", 256'(job_cnt), 256'(cnt_m));
            done_last = 0;
        end else if (prev_idle && prev_req != '0) begin
            g = rr_pick(prev_req, ptr_m);
            chk("grant_id", 256'(grant_id), 256'(g));
            chk("busy_after_grant", 256'(busy), 256'(1));
            owner = g;
            accepted = 0;
            grants.push_back(int'(grant_id));
        end

        if (req_rdy != '0) begin
            chk("req_rdy", 256'(req_rdy), (owner >= 0) ? 256'(1) << owner : 256'(0));
            chk("req_rdy_once", 256'(accepted), 256'(0));
            if (owner >= 0) begin
                exp_c = matmul(req_a[owner], req_b[owner]);
                accepted = 1;
                pend[owner] = 1'b0;
                n_acc[owner]++;
            end
        end

        if (resp_val != '0) begin
            chk("resp_val", 256'(resp_val), (owner >= 0) ? 256'(1) << owner : 256'(0));
            chk("resp_c", 256'(resp_c), 256'(exp_c));
            chk("resp_after_accept", 256'(accepted), 256'(1));
            if (owner >= 0 && resp_rdy[owner]) begin
                last_resp_c = resp_c;
                cnt_m++;
                ptr_m = (owner + 1) % NR;
                owner = -1;
                done_last = 1;
                jobs_done++;
            end
        end else if (busy) begin
            chk("resp_c_quiet", 256'(resp_c), 256'(0));
        end

        if (m_ab_we) begin
            mac_job = 1;
            mac_c   = matmul(m_a, m_b);
            mac_cnt = $urandom_range(1, 6);
            wait_k  = 0;
        end
        if (m_c_re) begin
            mac_job = 0;
            pend_c  = 1;
        end
        prev_idle = !busy;
        prev_req  = req_val;
    endtask

    task automatic step();
        @(negedge clk);
        // Result appears one cycle after the read strobe; junk otherwise.
        if (pend_c) begin
            m_c = mac_c;
            pend_c = 0;
        end else begin
            for (int e = 0; e < MN; e++) m_c[e] = 16'($urandom);
        end
        if (mac_job && !mac_hold && mac_cnt > 0) mac_cnt--;
        m_b2h_val = mac_job && !mac_hold && mac_cnt == 0;
        m_done    = m_b2h_val;
        m_h2b_rdy = h2b_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        for (int i = 0; i < NR; i++) begin
            if (!pend[i] && (rerequest || (auto_req && $urandom_range(0, 3) == 0))) new_job(i, 0);
            req_val[i]  = pend[i] && !(drop_en && owner == i && $urandom_range(0, 1) == 1);
            resp_rdy[i] = (resp_mode == 0) ? 1'b1 : (resp_mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
        #1;
        observe();
    endtask

    task automatic do_reset();
        #2;
        rstn = 1'b0;
        req_val = '0;
        #1;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_req_rdy", 256'(req_rdy), 256'(0));
        chk("rst_resp_val", 256'(resp_val), 256'(0));
        chk("rst_h2b_val", 256'(m_h2b_val), 256'(0));
        chk("rst_ab_we", 256'(m_ab_we), 256'(0));
        chk("rst_b2h_rdy", 256'(m_b2h_rdy), 256'(0));
        chk("rst_c_re", 256'(m_c_re), 256'(0));
        chk("rst_grant_id", 256'(grant_id), 256'(0));
        chk("rst_job_cnt", 256'(job_cnt), 256'(0));
        chk("rst_err", 256'(err_timeout), 256'(0));
        chk("rst_resp_c", 256'(resp_c), 256'(0));
        pend = '0; owner = -1; accepted = 0; ptr_m = 0; cnt_m = '0; exp_err = 0;
        prev_idle = 0; prev_req = '0; done_last = 0;
        mac_job = 0; pend_c = 0; mac_hold = 0; wait_k = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic run_jobs(input int target, input int budget, input string tag);
        int n = 0;
        while (jobs_done < target && n < budget) begin
            step();
            n++;
        end
        chk(tag, 256'(jobs_done >= target), 256'(1));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((pend != '0 || owner >= 0 || done_last) && n < 600) begin
            step();
            n++;
        end
        chk(tag, 256'(pend == '0 && owner < 0), 256'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, want finish before 1 ms");
        $fatal(1);
    end

    initial begin
        logic [MN-1:0][DWF-1:0] twos;
        logic [MN-1:0][DWF-1:0] rc;
        logic [0:0]             gid;
        int                     n;
        for (int e = 0; e < MN; e++) twos[e] = 16'd2;
        for (int i = 0; i < NR; i++) n_acc[i] = 0;
        req_val = '0; resp_rdy = '0; req_a = '0; req_b = '0;
        m_c = '0; m_h2b_rdy = 1'b0; m_b2h_val = 1'b0; m_done = 1'b0;

        do_reset();

        // Single job with A = I, B = all 2
        new_job(0, 1);
        run_jobs(1, 100, "single_done");
        step();
        chk("single_c", 256'(last_resp_c), 256'(twos));
        chk("single_rdy_cnt", 256'(n_acc[0]), 256'(1));

        // Contention from reset, then pointer back at 0
        do_reset();
        grants.delete();
        new_job(0, 0);
        new_job(1, 0);
        run_jobs(jobs_done + 2, 200, "contend_done");
        chk("contend_first", 256'(grants[0]), 256'(0));
        chk("contend_second", 256'(grants[1]), 256'(1));
        new_job(0, 0);
        new_job(1, 0);
        run_jobs(jobs_done + 1, 200, "contend_ptr_done");
        chk("contend_ptr_wrap", 256'(grants[2]), 256'(0));
        drain("contend_drain");

        // Fairness under continuous demand
        grants.delete();
        rerequest = 1;
        run_jobs(jobs_done + 6, 400, "fair_done");
        rerequest = 0;
        for (int k = 0; k < 6; k++) chk("fair_alternate", 256'(grants[k]), 256'(k % 2));
        drain("fair_drain");

        // Random traffic
        auto_req = 1; resp_mode = 1; drop_en = 1; h2b_rand = 1;
        run_jobs(jobs_done + 40, 4000, "random_done");
        auto_req = 0; drop_en = 0;
        drain("random_drain");
        resp_mode = 0; h2b_rand = 0;

        // Backpressure on the response
        resp_mode = 2;
        new_job(0, 0);
        new_job(1, 0);
        n = 0;
        while (resp_val == '0 && n < 200) begin step(); n++; end
        chk("bp_reach_resp", 256'(resp_val != '0), 256'(1));
        rc = resp_c;
        gid = grant_id;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("bp_resp_val", 256'(resp_val), 256'(1) << gid);
            chk("bp_resp_c_stable", 256'(resp_c), 256'(rc));
            chk("bp_grant", 256'(grant_id), 256'(gid));
        end
        resp_mode = 0;
        drain("bp_drain");

        // Watchdog: mac_top never answers
        mac_hold = 1;
        wait_k = 0;
        new_job(1, 0);
        n = 0;
        while (wait_k < 20 && n < 200) begin
            step();
            n++;
            if (wait_k == TO) chk("to_not_yet", 256'(err_timeout), 256'(0));
            if (wait_k == TO + 1) chk("to_fired", 256'(err_timeout), 256'(1));
            if (wait_k > 0) chk("to_in_wait", 256'(m_b2h_rdy && !m_c_re), 256'(1));
        end
        chk("to_reached", 256'(wait_k >= 20), 256'(1));
        mac_hold = 0;
        drain("to_drain");
        chk("to_sticky", 256'(err_timeout), 256'(1));

        // Reset during WAIT while requester 1 owns the engine
        new_job(0, 0);
        drain("pre_rst_drain");
        mac_hold = 1;
        new_job(1, 0);
        n = 0;
        while (wait_k < 3 && n < 100) begin step(); n++; end
        chk("mid_rst_in_wait", 256'(grant_id), 256'(1));
        do_reset();
        grants.delete();
        new_job(0, 0);
        new_job(1, 0);
        run_jobs(jobs_done + 1, 200, "post_rst_done");
        chk("post_rst_grant", 256'(grants[0]), 256'(0));
        drain("post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
